uart_tx_arbiter: RTL

- Shares one uart_tx instance between N_REQ byte producers, for example a command responder, debug streamer and status reporter.
- Accepts bytes over per-requester valid/ready and grants round-robin.
- Drives the transmitter's start/data strobes and waits for its done pulse before the next grant.
- Sits between the producers and uart_tx in the top-level UART subsystem.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/rr_priority_picker.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART subsystem types, defaults and helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_NB_DATA_DEFAULT = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker. Finds the first eligible
//               request scanning upward from last_grant+1 with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int N_REQ     = 4,
    parameter int NB_REQ_ID = 2
) (
    input  logic [N_REQ-1:0]     i_req,
    input  logic [NB_REQ_ID-1:0] i_last_grant,
    input  logic [N_REQ-1:0]     i_mask,
    output logic                 o_found,
    output logic [NB_REQ_ID-1:0] o_index
);

    logic [N_REQ-1:0] w_elig;

    assign w_elig = i_req & i_mask;

    // Indices above last_grant win first, then the wrapped lower half.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_found && w_elig[k] && (k > int'(i_last_grant))) begin
                o_found = 1'b1;
                o_index = NB_REQ_ID'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_found && w_elig[k] && (k <= int'(i_last_grant))) begin
                o_found = 1'b1;
                o_index = NB_REQ_ID'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one uart_tx between N_REQ byte
//               producers. Define UART_ARB_PKT_LOCK_EN to hold the grant on a
//               requester until it sends a byte flagged with i_req_last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NB_DATA   = c_NB_DATA_DEFAULT,
    parameter int N_REQ     = 4,
    parameter int NB_REQ_ID = clog2(N_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_tx_data,
    input  logic                     i_tx_done,
    output logic                     o_busy,
    output logic [NB_REQ_ID-1:0]     o_grant_id
);

    arb_state_t           r_state_q,      w_state_d;
    logic [N_REQ-1:0]     r_ready_q,      w_ready_d;
    logic                 r_tx_start_q,   w_tx_start_d;
    logic [NB_DATA-1:0]   r_tx_data_q,    w_tx_data_d;
    logic [NB_REQ_ID-1:0] r_grant_id_q,   w_grant_id_d;
    logic [NB_REQ_ID-1:0] r_last_grant_q, w_last_grant_d;

    logic [N_REQ-1:0]     w_mask;
    logic                 w_found;
    logic [NB_REQ_ID-1:0] w_pick_idx;

`ifdef UART_ARB_PKT_LOCK_EN
    logic                 r_lock_q,    w_lock_d;
    logic [NB_REQ_ID-1:0] r_lock_id_q, w_lock_id_d;

    assign w_mask = r_lock_q ? (N_REQ'(1) << r_lock_id_q) : '1;
`else
    logic w_unused_last;

    assign w_unused_last = ^i_req_last;
    assign w_mask        = '1;
`endif

    rr_priority_picker #(
        .N_REQ     (N_REQ),
        .NB_REQ_ID (NB_REQ_ID)
    ) u_picker (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant_q),
        .i_mask       (w_mask),
        .o_found      (w_found),
        .o_index      (w_pick_idx)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_ready_d      = '0;
        w_tx_start_d   = 1'b0;
        w_tx_data_d    = r_tx_data_q;
        w_grant_id_d   = r_grant_id_q;
        w_last_grant_d = r_last_grant_q;
`ifdef UART_ARB_PKT_LOCK_EN
        w_lock_d       = r_lock_q;
        w_lock_id_d    = r_lock_id_q;
`endif
        case (r_state_q)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_d    = ARB_START;
                    w_ready_d    = N_REQ'(1) << w_pick_idx;
                    w_tx_data_d  = i_req_data[int'(w_pick_idx)*NB_DATA +: NB_DATA];
                    w_grant_id_d = w_pick_idx;
`ifdef UART_ARB_PKT_LOCK_EN
                    // Rotation advances only at packet end, so the next
                    // packet goes to the following requester.
                    if (i_req_last[w_pick_idx]) begin
                        w_lock_d       = 1'b0;
                        w_last_grant_d = w_pick_idx;
                    end else begin
                        w_lock_d    = 1'b1;
                        w_lock_id_d = w_pick_idx;
                    end
`else
                    w_last_grant_d = w_pick_idx;
`endif
                end
            end
            ARB_START: begin
                w_tx_start_d = 1'b1;
                w_state_d    = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                if (i_tx_done) begin
                    w_state_d = ARB_IDLE;
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state_q      <= ARB_IDLE;
            r_ready_q      <= '0;
            r_tx_start_q   <= 1'b0;
            r_tx_data_q    <= '0;
            r_grant_id_q   <= '0;
            r_last_grant_q <= NB_REQ_ID'(N_REQ - 1);
`ifdef UART_ARB_PKT_LOCK_EN
            r_lock_q       <= 1'b0;
            r_lock_id_q    <= '0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_ready_q      <= w_ready_d;
            r_tx_start_q   <= w_tx_start_d;
            r_tx_data_q    <= w_tx_data_d;
            r_grant_id_q   <= w_grant_id_d;
            r_last_grant_q <= w_last_grant_d;
`ifdef UART_ARB_PKT_LOCK_EN
            r_lock_q       <= w_lock_d;
            r_lock_id_q    <= w_lock_id_d;
`endif
        end
    end

    assign o_req_ready = r_ready_q;
    assign o_tx_start  = r_tx_start_q;
    assign o_tx_data   = r_tx_data_q;
    assign o_grant_id  = r_grant_id_q;
    assign o_busy      = (r_state_q != ARB_IDLE);

endmodule

`default_nettype wire
